// File: rtl/screen_seq_pkg.sv
// screen_seq_pkg: shared types and XGA timing constants for the screen sequencer.
package screen_seq_pkg;
   typedef enum logic [1:0] {ST_SCR, ST_DONE} state_t;
   typedef enum logic [1:0] {PEND_NONE, PEND_NEXT, PEND_BACK} pend_t;
   typedef logic [11:0] rgb_t;
   localparam int H_ACTIVE = 1024;
   localparam int H_TOTAL  = 1344;
   localparam int V_ACTIVE = 768;
   localparam int V_TOTAL  = 806;
endpackage

// File: rtl/screen_sequencer_rect_hit.sv
// rect_hit: combinational test of the current pixel against one rectangle (right/bottom edges exclusive).
module rect_hit (
   input  logic [10:0] i_x,
   input  logic [9:0]  i_y,
   input  logic [10:0] i_w,
   input  logic [9:0]  i_h,
   input  logic [10:0] i_hcount,
   input  logic [9:0]  i_vcount,
   output logic        o_hit
);
   logic [11:0] w_x_end, w_y_end;
   assign w_x_end = {1'b0, i_x} + {1'b0, i_w};
   assign w_y_end = {2'b0, i_y} + {2'b0, i_h};
   assign o_hit = (i_hcount >= i_x) && ({1'b0, i_hcount} < w_x_end) &&
                  (i_vcount >= i_y) && ({2'b0, i_vcount} < w_y_end);
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: multi-screen UI overlay with frame-synchronous next/back navigation.
// Optional box-0 blink enabled by defining SCREEN_BLINK_EN.
module screen_sequencer
   import screen_seq_pkg::*;
#(
   parameter int NUM_SCREENS = 3,
   parameter int NUM_BOXES = 4,
   parameter logic [NUM_BOXES*11-1:0] BOX_X = {11'd600, 11'd400, 11'd140, 11'd100},
   parameter logic [NUM_BOXES*10-1:0] BOX_Y = {10'd500, 10'd300, 10'd50, 10'd40},
   parameter logic [NUM_BOXES*11-1:0] BOX_W = {11'd30, 11'd50, 11'd80, 11'd100},
   parameter logic [NUM_BOXES*10-1:0] BOX_H = {10'd30, 10'd50, 10'd40, 10'd50},
   parameter logic [NUM_BOXES*12-1:0] BOX_COLOR = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00},
   parameter logic [NUM_SCREENS*NUM_BOXES-1:0] SCREEN_MASK = {4'b1001, 4'b0100, 4'b0011},
   parameter logic [NUM_SCREENS-1:0] CAM_MASK = '0,
   parameter logic [11:0] BG_COLOR = 12'h000,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [11:0] cam_pixel,
   input  logic        arm,
   input  logic        btn_next,
   input  logic        btn_back,
   output logic [11:0] pixel_out,
   output logic [2:0]  screen_idx,
   output logic        done
);
   localparam logic [3:0] IDX_LAST = 4'(NUM_SCREENS - 1);
   logic r_next_prev, r_back_prev;
   pend_t r_pend;
   state_t r_state;
   logic [3:0] r_idx;
   logic w_fs, w_req_n, w_req_b;
   pend_t w_req, w_apply;
   state_t w_state_nxt;
   logic [3:0] w_idx_nxt;
   logic [NUM_BOXES-1:0] w_hit, w_en, w_box_en;
   logic [7:0] w_cam_mask;
   rgb_t w_bg, w_pix;
   assign w_fs = (hcount == 11'd0) && (vcount == 10'd0);
   assign w_req_n = btn_next & ~r_next_prev & arm;
   assign w_req_b = btn_back & ~r_back_prev & arm;
   assign w_req = (w_req_n ^ w_req_b) ? (w_req_n ? PEND_NEXT : PEND_BACK) : PEND_NONE;
   assign w_apply = w_fs ? r_pend : PEND_NONE;
   // DONE keeps r_idx == NUM_SCREENS, so BACK from DONE is an ordinary decrement
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt = r_idx;
      if (w_apply == PEND_NEXT && r_state == ST_SCR) begin
         w_idx_nxt = r_idx + 4'd1;
         w_state_nxt = (r_idx == IDX_LAST) ? ST_DONE : ST_SCR;
      end
      if (w_apply == PEND_BACK) begin
         w_state_nxt = ST_SCR;
         w_idx_nxt = (r_idx == 4'd0) ? 4'd0 : r_idx - 4'd1;
      end
   end
   for (genvar b = 0; b < NUM_BOXES; b++) begin : g_hit
      rect_hit u_hit (
         .i_x(BOX_X[b*11 +: 11]),
         .i_y(BOX_Y[b*10 +: 10]),
         .i_w(BOX_W[b*11 +: 11]),
         .i_h(BOX_H[b*10 +: 10]),
         .i_hcount(hcount),
         .i_vcount(vcount),
         .o_hit(w_hit[b])
      );
   end
   always_comb begin
      w_en = '0;
      for (int s = 0; s < NUM_SCREENS; s++)
         if (w_idx_nxt == 4'(s)) w_en = SCREEN_MASK[s*NUM_BOXES +: NUM_BOXES];
   end
`ifdef SCREEN_BLINK_EN
   logic [7:0] r_frame_cnt, w_cnt_nxt;
   logic r_phase, w_phase_nxt;
   // counter holds frames seen in the current half-period; a screen change starts a fresh visible period
   always_comb begin
      w_cnt_nxt = r_frame_cnt;
      w_phase_nxt = r_phase;
      if (w_fs && w_idx_nxt != r_idx) begin
         w_cnt_nxt = 8'd1;
         w_phase_nxt = 1'b0;
      end else if (w_fs) begin
         w_cnt_nxt = (r_frame_cnt == 8'(BLINK_FRAMES)) ? 8'd1 : r_frame_cnt + 8'd1;
         w_phase_nxt = (r_frame_cnt == 8'(BLINK_FRAMES)) ? ~r_phase : r_phase;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_phase <= 1'b0;
      end else begin
         r_frame_cnt <= w_cnt_nxt;
         r_phase <= w_phase_nxt;
      end
   end
   assign w_box_en = w_en & ~NUM_BOXES'(w_phase_nxt);
`else
   assign w_box_en = w_en;
`endif
   assign w_cam_mask = 8'(CAM_MASK);
   assign w_bg = w_cam_mask[w_idx_nxt[2:0]] ? cam_pixel : BG_COLOR;
   always_comb begin
      w_pix = w_bg;
      for (int b = NUM_BOXES - 1; b >= 0; b--)
         if (w_hit[b] && w_box_en[b]) w_pix = BOX_COLOR[b*12 +: 12];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_prev <= 1'b0;
         r_back_prev <= 1'b0;
         r_pend <= PEND_NONE;
         r_state <= ST_SCR;
         r_idx <= '0;
         pixel_out <= '0;
         screen_idx <= '0;
         done <= 1'b0;
      end else begin
         r_next_prev <= btn_next;
         r_back_prev <= btn_back;
         r_pend <= (w_req != PEND_NONE) ? w_req : (w_fs ? PEND_NONE : r_pend);
         r_state <= w_state_nxt;
         r_idx <= w_idx_nxt;
         pixel_out <= (w_state_nxt == ST_DONE) ? 12'h000 : w_pix;
         screen_idx <= w_idx_nxt[2:0];
         done <= (w_state_nxt == ST_DONE);
      end
   end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed self-checking bench for screen_sequencer.
module tb_screen_sequencer;
   logic clk = 1'b0;
   logic rst, arm, btn_next, btn_back;
   logic [10:0] hcount;
   logic [9:0] vcount;
   logic [11:0] cam_pixel, pixel_out;
   logic [2:0] screen_idx;
   logic done;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   screen_sequencer #(
      .NUM_SCREENS(3),
      .NUM_BOXES(4),
      .BOX_X({11'd600, 11'd400, 11'd140, 11'd100}),
      .BOX_Y({10'd500, 10'd300, 10'd50, 10'd40}),
      .BOX_W({11'd30, 11'd50, 11'd80, 11'd100}),
      .BOX_H({10'd30, 10'd50, 10'd40, 10'd50}),
      .BOX_COLOR({12'hFFF, 12'h00F, 12'h0F0, 12'hF00}),
      .SCREEN_MASK({4'b1001, 4'b0100, 4'b0011}),
      .CAM_MASK(3'b001),
      .BG_COLOR(12'h123),
      .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .cam_pixel(cam_pixel),
      .arm(arm), .btn_next(btn_next), .btn_back(btn_back),
      .pixel_out(pixel_out), .screen_idx(screen_idx), .done(done)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask
   task automatic mid();
      hcount = 11'd500;
      vcount = 10'd400;
   endtask
   task automatic frame_start();
      hcount = 11'd0;
      vcount = 10'd0;
      tick();
      mid();
   endtask
   task automatic press(input logic nxt, input logic bck);
      btn_next = nxt;
      btn_back = bck;
      tick();
      btn_next = 1'b0;
      btn_back = 1'b0;
      tick();
   endtask
   task automatic pix_at(input logic [10:0] h, input logic [9:0] v, input logic [11:0] cam);
      hcount = h;
      vcount = v;
      cam_pixel = cam;
      tick();
      mid();
   endtask
   initial begin
      rst = 1'b1; arm = 1'b0; btn_next = 1'b0; btn_back = 1'b0; cam_pixel = 12'h0;
      mid();
      tick();
      tick();
      chk("rst_pixel", pixel_out, 12'h000);
      chk("rst_idx", 12'(screen_idx), 12'd0);
      chk("rst_done", 12'(done), 12'd0);
      rst = 1'b0;
      arm = 1'b1;
      pix_at(11'd150, 10'd60, 12'hABC);
      chk("s0_box0", pixel_out, 12'hF00);
      press(1'b1, 1'b0);
      chk("t1_midframe_idx", 12'(screen_idx), 12'd0);
      frame_start();
      chk("t1_after_fs_idx", 12'(screen_idx), 12'd1);
      pix_at(11'd150, 10'd60, 12'hABC);
      chk("t1_s1_bg", pixel_out, 12'h123);
      arm = 1'b0;
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      frame_start();
      frame_start();
      frame_start();
      chk("t2_disarmed_idx", 12'(screen_idx), 12'd1);
      chk("t2_disarmed_done", 12'(done), 12'd0);
      arm = 1'b1;
      press(1'b0, 1'b1);
      frame_start();
      chk("t3_back_to0", 12'(screen_idx), 12'd0);
      for (int i = 1; i <= 3; i++) begin
         press(1'b1, 1'b0);
         frame_start();
         chk($sformatf("t3_next_%0d", i), 12'(screen_idx), 12'(i));
      end
      chk("t3_done", 12'(done), 12'd1);
      pix_at(11'd150, 10'd60, 12'hABC);
      chk("t3_done_pixel", pixel_out, 12'h000);
      press(1'b1, 1'b0);
      frame_start();
      chk("t3_next_in_done_idx", 12'(screen_idx), 12'd3);
      chk("t3_next_in_done_done", 12'(done), 12'd1);
      press(1'b0, 1'b1);
      frame_start();
      chk("t3_back_from_done_idx", 12'(screen_idx), 12'd2);
      chk("t3_back_from_done_done", 12'(done), 12'd0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      frame_start();
      chk("overwrite_idx", 12'(screen_idx), 12'd1);
      hcount = 11'd0;
      vcount = 10'd0;
      btn_next = 1'b1;
      tick();
      btn_next = 1'b0;
      mid();
      tick();
      chk("fs_cycle_req_held", 12'(screen_idx), 12'd1);
      frame_start();
      chk("fs_cycle_req_applied", 12'(screen_idx), 12'd2);
      press(1'b0, 1'b1);
      frame_start();
      press(1'b0, 1'b1);
      frame_start();
      chk("back_to_s0", 12'(screen_idx), 12'd0);
      pix_at(11'd150, 10'd60, 12'hABC);
      chk("t4_overlap_box0", pixel_out, 12'hF00);
      pix_at(11'd210, 10'd60, 12'hABC);
      chk("t4_box1_only", pixel_out, 12'h0F0);
      pix_at(11'd199, 10'd60, 12'hABC);
      chk("t4_box0_right_edge", pixel_out, 12'hF00);
      pix_at(11'd220, 10'd60, 12'h5A5);
      chk("t4_box1_excl_edge_cam", pixel_out, 12'h5A5);
      pix_at(11'd300, 10'd300, 12'h777);
      chk("t4_cam_a", pixel_out, 12'h777);
      pix_at(11'd300, 10'd300, 12'h111);
      chk("t4_cam_b", pixel_out, 12'h111);
      press(1'b1, 1'b1);
      frame_start();
      chk("t5_simultaneous", 12'(screen_idx), 12'd0);
      press(1'b0, 1'b1);
      frame_start();
      chk("t5_back_at_s0", 12'(screen_idx), 12'd0);
`ifdef SCREEN_BLINK_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         frame_start();
         pix_at(11'd150, 10'd60, 12'hABC);
         chk($sformatf("t6_blink_frame_%0d", k), pixel_out, ((k / 2) % 2 == 1) ? 12'h0F0 : 12'hF00);
      end
`endif
      press(1'b1, 1'b0);
      frame_start();
      chk("t6_pre_reset_idx", 12'(screen_idx), 12'd1);
      press(1'b1, 1'b0);
      hcount = 11'd150;
      vcount = 10'd60;
      rst = 1'b1;
      tick();
      chk("t6_rst_pixel", pixel_out, 12'h000);
      chk("t6_rst_idx", 12'(screen_idx), 12'd0);
      chk("t6_rst_done", 12'(done), 12'd0);
      rst = 1'b0;
      mid();
      frame_start();
      chk("t6_pending_cleared", 12'(screen_idx), 12'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
